// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer: access types,
// FIFO entry layout, byte-lane masks and load-lane extraction.
package store_buffer_pkg;

  typedef enum logic [2:0] {
    DT_B  = 3'd0,
    DT_H  = 3'd1,
    DT_W  = 3'd2,
    DT_BU = 3'd4,
    DT_HU = 3'd5
  } mem_dt_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [1:0]  boff;
    mem_dt_e     dt;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  // Misaligned halves/words are aligned down to their natural boundary.
  function automatic logic [1:0] align_off(input mem_dt_e dt, input logic [1:0] off);
    case (dt)
      DT_B, DT_BU: align_off = off;
      DT_H, DT_HU: align_off = {off[1], 1'b0};
      default:     align_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] dt_mask(input mem_dt_e dt, input logic [1:0] off);
    case (dt)
      DT_B, DT_BU: dt_mask = 4'b0001 << off;
      DT_H, DT_HU: dt_mask = 4'b0011 << {off[1], 1'b0};
      default:     dt_mask = 4'b1111;
    endcase
  endfunction

  // data is in word-lane position; result is right-aligned and extended.
  function automatic logic [31:0] lane_extract(input logic [31:0] data, input logic [3:0] mask,
                                               input logic [1:0] off, input mem_dt_e dt);
    logic [31:0] lanes;
    logic [31:0] sh;
    lanes = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    sh    = lanes >> {align_off(dt, off), 3'b000};
    case (dt)
      DT_B:    lane_extract = {{24{sh[7]}}, sh[7:0]};
      DT_BU:   lane_extract = {24'd0, sh[7:0]};
      DT_H:    lane_extract = {{16{sh[15]}}, sh[15:0]};
      DT_HU:   lane_extract = {16'd0, sh[15:0]};
      default: lane_extract = sh;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer. The master modport is the
// environment (core + memory), the slave modport is the buffer itself.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic [31:0] c_addr;
  logic [31:0] c_wd;
  logic        c_we;
  logic        c_re;
  mem_dt_e     c_dt;
  logic [31:0] c_rd;
  logic        c_stall;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic        m_we;
  mem_dt_e     m_dt;
  logic [31:0] m_rd;
  logic        empty;

  modport master (
    output c_addr, c_wd, c_we, c_re, c_dt, m_rd,
    input  c_rd, c_stall, m_addr, m_wd, m_we, m_dt, empty
  );

  modport slave (
    input  c_addr, c_wd, c_we, c_re, c_dt, m_rd,
    output c_rd, c_stall, m_addr, m_wd, m_we, m_dt, empty
  );

endinterface

// File: rtl/store_buffer_match.sv
// Youngest-overlap search over the store FIFO for the current load: reports a hit,
// whether that entry covers every loaded byte, and its slot index.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [29:0]                waddr_i [DEPTH],
  input  logic [3:0]                 mask_i  [DEPTH],
  input  logic [DEPTH-1:0]           vld_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx_i,
  input  logic [29:0]                laddr_i,
  input  logic [3:0]                 lmask_i,
  output logic                       hit_o,
  output logic                       cover_o,
  output logic [$clog2(DEPTH)-1:0]   idx_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] pos_s;
  logic [3:0]    ov_s;

  // Walk oldest to youngest so the last match (the youngest store) wins.
  always_comb begin
    hit_o   = 1'b0;
    cover_o = 1'b0;
    idx_o   = '0;
    pos_s   = '0;
    ov_s    = 4'b0000;
    for (int k = DEPTH; k >= 1; k--) begin
      pos_s = wr_idx_i - AW'(k);
      ov_s  = mask_i[pos_s] & lmask_i;
      if (vld_i[pos_s] && (waddr_i[pos_s] == laddr_i) && (ov_s != 4'b0000)) begin
        hit_o   = 1'b1;
        cover_o = (ov_s == lmask_i);
        idx_o   = pos_s;
      end else begin
        hit_o = hit_o;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: retired stores queue in a FIFO and drain whenever the
// memory port is free; loads forward from the youngest fully covering store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  sb_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [29:0]      waddr_s [DEPTH];
  logic [3:0]       mask_s  [DEPTH];
  logic [AW-1:0]    rd_idx_s, wr_idx_s, hit_idx_s;
  logic [3:0]       lmask_s;
  logic             empty_s, full_s, hit_s, cover_s, hazard_s, enq_s, drain_s;
  sb_entry_t        new_s;

  assign rd_idx_s = rd_ptr_q[AW-1:0];
  assign wr_idx_s = wr_ptr_q[AW-1:0];
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx_s == rd_idx_s);
  assign lmask_s  = dt_mask(bus.c_dt, bus.c_addr[1:0]);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      waddr_s[i] = ent_q[i].waddr;
      mask_s[i]  = ent_q[i].mask;
    end
  end

  store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .waddr_i  (waddr_s),
    .mask_i   (mask_s),
    .vld_i    (vld_q),
    .wr_idx_i (wr_idx_s),
    .laddr_i  (bus.c_addr[31:2]),
    .lmask_i  (lmask_s),
    .hit_o    (hit_s),
    .cover_o  (cover_s),
    .idx_o    (hit_idx_s)
  );

  // A partially covered load yields the port to the drain so the hazard clears.
  assign hazard_s = bus.c_re && hit_s && !cover_s;
  assign enq_s    = bus.c_we && !full_s;
  assign drain_s  = !empty_s && (!bus.c_re || hazard_s);

  always_comb begin
    new_s.waddr = bus.c_addr[31:2];
    new_s.boff  = align_off(bus.c_dt, bus.c_addr[1:0]);
    new_s.dt    = bus.c_dt;
    new_s.data  = bus.c_wd;
    new_s.mask  = lmask_s;
  end

  // Port mux, stall and forwarding datapath.
  always_comb begin
    bus.m_we    = rst && drain_s;
    bus.c_stall = rst && (hazard_s || (bus.c_we && full_s));
    bus.empty   = empty_s;
    if (drain_s) begin
      bus.m_addr = {ent_q[rd_idx_s].waddr, ent_q[rd_idx_s].boff};
      bus.m_wd   = ent_q[rd_idx_s].data;
      bus.m_dt   = ent_q[rd_idx_s].dt;
    end else begin
      bus.m_addr = bus.c_addr;
      bus.m_wd   = bus.c_wd;
      bus.m_dt   = bus.c_dt;
    end
    if (hit_s && cover_s) begin
      bus.c_rd = lane_extract(ent_q[hit_idx_s].data << {ent_q[hit_idx_s].boff, 3'b000},
                              ent_q[hit_idx_s].mask, bus.c_addr[1:0], bus.c_dt);
    end else begin
      bus.c_rd = bus.m_rd;
    end
  end

  // Pointer and valid-bit next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (drain_s) begin
      rd_ptr_d           = rd_ptr_q + (AW+1)'(1);
      vld_d[rd_idx_s]    = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (enq_s) begin
      wr_ptr_d           = wr_ptr_q + (AW+1)'(1);
      vld_d[wr_idx_s]    = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Control state; reset discards anything still buffered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    if (rst && enq_s) begin
      ent_q[wr_idx_s] <= new_s;
    end
  end

endmodule
